// File: rtl/seq_shifter.sv
// Multi-cycle shifter: moves the operand at most STEP bit positions per clock
// until the requested amount is consumed, then holds the result for the consumer.
module seq_shifter #(
   parameter int WIDTH = 32,
   parameter int STEP  = 4,
   localparam int SHW  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [SHW-1:0]   shamt,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] r,
   output logic             busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [2:0] OP_SRL = 3'b000;
   localparam logic [2:0] OP_SLL = 3'b001;
   localparam logic [2:0] OP_SRA = 3'b010;
   localparam logic [2:0] OP_ROR = 3'b011;
   localparam logic [2:0] OP_ROL = 3'b100;

   localparam logic [SHW:0] WIDTH_C = (SHW+1)'(WIDTH);
   localparam logic [SHW:0] STEP_C  = (SHW+1)'(STEP);

   logic [1:0]       state_q,     state_d;
   logic [WIDTH-1:0] work_q,      work_d;
   logic [SHW-1:0]   rem_q,       rem_d;
   logic [2:0]       op_q,        op_d;
   logic             sign_q,      sign_d;
   logic             in_ready_q,  in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q,      busy_d;

   logic [SHW:0]     rem_ext_s;
   logic [SHW:0]     step_s;
   logic [SHW-1:0]   rem_next_s;
   logic [SHW-1:0]   acc_rem_s;
   logic             pass_op_s;

   // One partial shift by amt (0..STEP); sra fills with the sign of the original operand.
   function automatic logic [WIDTH-1:0] shift_step(
      input logic [WIDTH-1:0] val,
      input logic [2:0]       opc,
      input logic             fill,
      input logic [SHW:0]     amt
   );
      logic [WIDTH-1:0] res;
      logic [WIDTH-1:0] top_mask;
      logic [SHW:0]     inv;
      res      = val;
      inv      = WIDTH_C - amt;
      top_mask = ~({WIDTH{1'b1}} >> amt);
      case (opc)
         OP_SRL:  res = val >> amt;
         OP_SLL:  res = val << amt;
         OP_SRA:  res = (val >> amt) | (fill ? top_mask : {WIDTH{1'b0}});
         OP_ROR:  res = (val >> amt) | (val << inv);
         OP_ROL:  res = (val << amt) | (val >> inv);
         default: res = val;
      endcase
      return res;
   endfunction

   // Per-cycle step size: never more than what remains, so the counter cannot underflow.
   always_comb begin
      rem_ext_s  = {1'b0, rem_q};
      step_s     = (rem_ext_s > STEP_C) ? STEP_C : rem_ext_s;
      rem_next_s = rem_q - step_s[SHW-1:0];
      pass_op_s  = (op > OP_ROL);
      acc_rem_s  = pass_op_s ? {SHW{1'b0}} : shamt;
   end

   // Next-state logic for the control FSM and datapath.
   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      rem_d   = rem_q;
      op_d    = op_q;
      sign_d  = sign_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               work_d  = a;
               op_d    = op;
               sign_d  = a[WIDTH-1];
               rem_d   = acc_rem_s;
               state_d = (acc_rem_s != {SHW{1'b0}}) ? S_SHIFT : S_DONE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SHIFT: begin
            work_d  = shift_step(work_q, op_q, sign_q, step_s);
            rem_d   = rem_next_s;
            state_d = (rem_next_s == {SHW{1'b0}}) ? S_DONE : S_SHIFT;
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            rem_d   = {SHW{1'b0}};
         end
      endcase
   end

   // Handshake flags are decoded from the next state so they leave the block registered.
   always_comb begin
      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
      busy_d      = (state_d == S_SHIFT);
   end

   // State registers with synchronous reset taking priority over everything else.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         work_q      <= {WIDTH{1'b0}};
         rem_q       <= {SHW{1'b0}};
         op_q        <= 3'b000;
         sign_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         work_q      <= work_d;
         rem_q       <= rem_d;
         op_q        <= op_d;
         sign_q      <= sign_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign r         = work_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter (WIDTH=32, STEP=4): result, latency,
// busy profile, DONE hold behaviour and reset in mid-shift.
module tb_seq_shifter;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [4:0]  shamt;
   logic [2:0]  op;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] r;
   logic        busy;

   typedef struct {
      logic [31:0] res;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   seq_shifter #(.WIDTH(32), .STEP(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .shamt    (shamt),
      .op       (op),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .r        (r),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_shift(input logic [2:0] o, input logic [31:0] v, input int s);
      case (o)
         3'd0:    return v >> s;
         3'd1:    return v << s;
         3'd2:    return 32'($signed(v) >>> s);
         3'd3:    return (s == 0) ? v : ((v >> s) | (v << (32 - s)));
         3'd4:    return (s == 0) ? v : ((v << s) | (v >> (32 - s)));
         default: return v;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Accept one operation, follow it to DONE, hold it `hold` cycles, release it.
   task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [4:0] sh, input int hold);
      exp_t e;
      int   cyc;
      int   busy_n;
      check_eq("pre_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      a        = av;
      shamt    = sh;
      op       = o;
      e.res    = ref_shift(o, av, int'(sh));
      e.lat    = (o > 3'd4 || sh == 5'd0) ? 1 : 1 + (int'(sh) + 3) / 4;
      sb.push_back(e);
      step();
      in_valid = 1'b0;
      a        = $urandom;
      shamt    = 5'($urandom);
      op       = 3'($urandom);
      cyc      = 1;
      busy_n   = 0;
      while (!out_valid && cyc < 40) begin
         if (busy) busy_n++;
         check_eq("in_ready_in_shift", 32'(in_ready), 32'd0);
         in_valid = 1'b1;
         step();
         cyc++;
      end
      in_valid = 1'b0;
      e = sb.pop_front();
      check_eq("latency", 32'(cyc), 32'(e.lat));
      check_eq("result", r, e.res);
      check_eq("busy_cycles", 32'(busy_n), 32'(e.lat - 1));
      check_eq("busy_in_done", 32'(busy), 32'd0);
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1;
         a        = $urandom;
         step();
         check_eq("hold_valid", 32'(out_valid), 32'd1);
         check_eq("hold_result", r, e.res);
         check_eq("hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check_eq("release_in_ready", 32'(in_ready), 32'd1);
      check_eq("release_valid", 32'(out_valid), 32'd0);
   endtask

   initial begin
      int seen;
      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = 32'h0;
      shamt     = 5'd0;
      op        = 3'd0;
      out_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_r", r, 32'h0);

      run_op(3'b000, 32'h8000_0000, 5'd4, 0);
      run_op(3'b010, 32'h8000_0000, 5'd31, 0);
      run_op(3'b001, 32'h0000_0001, 5'd31, 1);
      run_op(3'b011, 32'h0000_0001, 5'd4, 0);
      run_op(3'b100, 32'h8000_0001, 5'd1, 0);
      run_op(3'b001, 32'h1234_5678, 5'd0, 3);
      run_op(3'b111, 32'hDEAD_BEEF, 5'd17, 0);
      run_op(3'b010, 32'h7FFF_FFF0, 5'd7, 0);
      for (int i = 0; i < 24; i++) begin
         run_op(3'($urandom_range(0, 7)), $urandom, 5'($urandom), int'($urandom_range(0, 2)));
      end

      // Reset in the third SHIFT cycle of a 20-bit srl discards the operation.
      in_valid = 1'b1;
      a        = 32'hFFFF_0000;
      shamt    = 5'd20;
      op       = 3'b000;
      step();
      in_valid = 1'b0;
      step();
      step();
      check_eq("pre_rst_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("mid_rst_busy", 32'(busy), 32'd0);
      check_eq("mid_rst_r", r, 32'h0);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (out_valid || busy) seen++;
      end
      check_eq("no_result_after_rst", 32'(seen), 32'd0);

      // Reset wins over a simultaneous acceptance.
      in_valid = 1'b1;
      a        = 32'hCAFE_F00D;
      shamt    = 5'd0;
      op       = 3'b001;
      rst      = 1'b1;
      step();
      rst      = 1'b0;
      in_valid = 1'b0;
      check_eq("rst_prio_in_ready", 32'(in_ready), 32'd1);
      check_eq("rst_prio_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_prio_r", r, 32'h0);

      run_op(3'b000, 32'hA5A5_A5A5, 5'd13, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 Parameter WIDTH, default 32: data width in bits; SHALL be a power of two, at least 8.
REQ-002 Parameter STEP, default 4: maximum bit positions shifted per cycle; SHALL be a power of two, 1..WIDTH/2.
REQ-003 Local SHW = clog2(WIDTH): shift-amount width.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  operand presented.
REQ-007 in_ready  out  1  block can accept an operand.
REQ-008 a  in  WIDTH  operand.
REQ-009 shamt  in  SHW  shift amount, unsigned.
REQ-010 op  in  3  000 srl, 001 sll, 010 sra, 011 ror, 100 rol, 101..111 pass-through.
REQ-011 out_valid  out  1  result available.
REQ-012 out_ready  in  1  consumer takes result.
REQ-013 r  out  WIDTH  result.
REQ-014 busy  out  1  high in SHIFT state.

Function
REQ-015 FSM states SHIFT, IDLE, DONE. in_ready = (state==IDLE); out_valid = (state==DONE); busy = (state==SHIFT).
REQ-016 Acceptance = in_valid & in_ready at a clock edge; a, shamt, op SHALL be captured then; later input changes ignored until next acceptance.
REQ-017 On acceptance: working register <= a; remaining <= shamt, or 0 for pass-through ops; next state SHIFT if remaining nonzero, else DONE.
REQ-018 In SHIFT, each edge shifts working register by k = min(STEP, remaining) and sets remaining <= remaining - k; when the new remaining is 0, next state DONE.
REQ-019 srl: zero-fill from MSB; sll: zero-fill from LSB; sra: fill with bit WIDTH-1 of original a; ror/rol: bits wrap end to end, modulo WIDTH.
REQ-020 Latency: accept in cycle n -> out_valid high in cycle n+1+ceil(shamt/STEP); pass-through and shamt=0 give cycle n+1.
REQ-021 Final result SHALL equal the single-step combinational result of the same op on a with shift shamt.
REQ-022 In DONE, r and out_valid SHALL hold stable while out_ready is low; on the edge with out_ready high, next state IDLE.
REQ-023 No new acceptance in SHIFT or DONE; in_valid there is ignored (in_ready low), no back-to-back overlap.
REQ-024 r SHALL always drive the working register; r is valid only while out_valid is high.
REQ-025 shamt = WIDTH-1 SHALL complete correctly; remaining never underflows.

Reset
REQ-026 rst high at an edge, in any state including mid-SHIFT: state <= IDLE, working register <= 0, remaining <= 0; any in-flight operation discarded.
REQ-027 Outputs after reset: in_ready=1, out_valid=0, busy=0, r=0.
REQ-028 rst has priority over acceptance and over out_ready in the same cycle.

Verification (WIDTH=32, STEP=4)
REQ-029 srl a=0x80000000 shamt=4, accept cycle n -> r=0x08000000, out_valid in cycle n+2, busy high in cycle n+1 only.
REQ-030 sra a=0x80000000 shamt=31 -> r=0xFFFFFFFF, out_valid in cycle n+9; sll a=0x00000001 shamt=31 -> r=0x80000000, cycle n+9.
REQ-031 ror a=0x00000001 shamt=4 -> r=0x10000000; rol a=0x80000001 shamt=1 -> r=0x00000003, out_valid cycle n+2.
REQ-032 sll a=0x12345678 shamt=0 -> r=0x12345678, out_valid cycle n+1; out_ready low 3 cycles -> r, out_valid held, in_ready low, in_valid ignored; out_ready high -> IDLE next cycle.
REQ-033 op=111 a=0xDEADBEEF shamt=17 -> r=0xDEADBEEF, out_valid cycle n+1.
REQ-034 srl shamt=20, rst high in 3rd SHIFT cycle -> next cycle in_ready=1, out_valid=0, busy=0, r=0; no result ever emitted.
